// File: rtl/score_display_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_display_sequencer                                                  |
// | Round-robin double-dabble hand display plus blinking status word.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module score_display_sequencer #(
  parameter int NUM_HANDS = 2,
  parameter int HAND_W    = 6,
  parameter int BLINK_DIV = 25_000_000,
  parameter bit LZB       = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_HANDS*HAND_W-1:0]     hand_values_i,
  input  logic [2:0]                      msg_sel_i,
  input  logic                            blink_en_i,
  output logic [(2*NUM_HANDS+4)*7-1:0]    hex_out_o,
  output logic                            refresh_done_o
);
  localparam int              IDX_W     = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
  localparam int              BLK_W     = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HANDS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_DIV - 1);
  localparam logic [6:0]      SEG_BLANK = 7'h7F;
  localparam logic [6:0]      SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HAND_W-1:0]   sreg_q, sreg_d;
  logic [7:0]          bcd_q, bcd_d, bcd_adj;
  logic [2:0]          cnt_q, cnt_d;
  logic                ovr_q, ovr_d;
  logic [6:0]          tens_q [NUM_HANDS];
  logic [6:0]          ones_q [NUM_HANDS];
  logic                hovr_q [NUM_HANDS];
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                phase_q, phase_d;
  logic [2:0]          msg_q;
  logic [(2*NUM_HANDS+4)*7-1:0] hex_q, hex_d;
  logic                done_q;
  logic [HAND_W-1:0]   hand_cur;
  logic                over_range;
  logic                store_last;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: seg_digit = 7'h40;
      4'd1: seg_digit = 7'h79;
      4'd2: seg_digit = 7'h24;
      4'd3: seg_digit = 7'h30;
      4'd4: seg_digit = 7'h19;
      4'd5: seg_digit = 7'h12;
      4'd6: seg_digit = 7'h02;
      4'd7: seg_digit = 7'h78;
      4'd8: seg_digit = 7'h00;
      4'd9: seg_digit = 7'h10;
      default: seg_digit = SEG_DASH;
    endcase
  endfunction

  // Packed {slot3, slot2, slot1, slot0}; slot3 is the leftmost character.
  function automatic logic [27:0] msg_glyphs(input logic [2:0] m);
    case (m)
      3'd0: msg_glyphs = {7'h0C, 7'h47, 7'h08, 7'h11};  // PLAY
      3'd1: msg_glyphs = {7'h12, 7'h07, 7'h2F, 7'h07};  // STRT
      3'd2: msg_glyphs = {7'h21, 7'h06, 7'h08, 7'h47};  // DEAL
      3'd3: msg_glyphs = {7'h7F, 7'h41, 7'h4F, 7'h2B};  // WIN
      3'd4: msg_glyphs = {7'h47, 7'h40, 7'h12, 7'h06};  // LOSE
      3'd5: msg_glyphs = {7'h7F, 7'h07, 7'h4F, 7'h06};  // TIE
      3'd6: msg_glyphs = {7'h03, 7'h41, 7'h12, 7'h07};  // BUST
      default: msg_glyphs = {4{SEG_BLANK}};
    endcase
  endfunction

  assign hand_cur   = hand_values_i[idx_q*HAND_W +: HAND_W];
  assign over_range = (8'(hand_cur) > 8'd99);
  assign store_last = (state_q == S_STORE) && (idx_q == LAST_IDX);
  assign bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
  assign bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
      S_LOAD: begin
        sreg_d = hand_cur;
        bcd_d  = '0;
        ovr_d  = over_range;
        cnt_d  = 3'(HAND_W);
        state_d = over_range ? S_STORE : S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d  = {bcd_adj[6:0], sreg_q[HAND_W-1]};
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_STORE;
      end
      S_STORE: begin
        state_d = S_LOAD;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sreg_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Only STORE commits digits, so an aborted conversion never reaches the display.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        tens_q[h] <= SEG_BLANK;
        ones_q[h] <= SEG_BLANK;
        hovr_q[h] <= 1'b0;
      end
    end else if (state_q == S_STORE) begin
      tens_q[idx_q] <= (LZB && bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg_digit(bcd_q[7:4]);
      ones_q[idx_q] <= seg_digit(bcd_q[3:0]);
      hovr_q[idx_q] <= ovr_q;
    end
  end

  // A message change restarts the blink period so the new word is seen in full.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (msg_sel_i != msg_q) begin
      blk_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (blk_cnt_q == BLK_MAX) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    end
  end

  always_comb begin
    hex_d = '1;
    hex_d[27:0] = (blink_en_i && phase_d) ? {4{SEG_BLANK}} : msg_glyphs(msg_sel_i);
    for (int h = 0; h < NUM_HANDS; h++) begin
      hex_d[(4+2*h)*7 +: 7] = hovr_q[h] ? SEG_DASH : ones_q[h];
      hex_d[(5+2*h)*7 +: 7] = hovr_q[h] ? SEG_DASH : tens_q[h];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      msg_q     <= 3'd7;
      hex_q     <= '1;
      done_q    <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      msg_q     <= msg_sel_i;
      hex_q     <= hex_d;
      done_q    <= store_last;
    end
  end

  assign hex_out_o      = hex_q;
  assign refresh_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_score_display_sequencer                                               |
// | Directed vectors for conversion, blanking, over-range, blink and reset. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_score_display_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] hv_a;
  logic [6:0]  hv_b;
  logic [2:0]  msg;
  logic        blink;
  logic [55:0] hex_a;
  logic [41:0] hex_b;
  logic        done_a, done_b;
  int          n_chk = 0;
  int          n_err = 0;

  localparam logic [27:0] W_STRT  = {7'h12, 7'h07, 7'h2F, 7'h07};
  localparam logic [27:0] W_WIN   = {7'h7F, 7'h41, 7'h4F, 7'h2B};
  localparam logic [27:0] W_LOSE  = {7'h47, 7'h40, 7'h12, 7'h06};
  localparam logic [27:0] W_BLANK = {4{7'h7F}};

  always #5 clk = ~clk;

  score_display_sequencer #(.NUM_HANDS(2), .HAND_W(6), .BLINK_DIV(8), .LZB(1'b1)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .hand_values_i(hv_a), .msg_sel_i(msg),
    .blink_en_i(blink), .hex_out_o(hex_a), .refresh_done_o(done_a));

  score_display_sequencer #(.NUM_HANDS(1), .HAND_W(7), .BLINK_DIV(4), .LZB(1'b1)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .hand_values_i(hv_b), .msg_sel_i(msg),
    .blink_en_i(blink), .hex_out_o(hex_b), .refresh_done_o(done_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!done_a && cyc < 200);
    if (!done_a) check("timeout_a", 64'(done_a), 64'd1);
  endtask

  task automatic wait_done_b(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!done_b && cyc < 200);
    if (!done_b) check("timeout_b", 64'(done_b), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic bad;
    logic [27:0] hands;
    reset = 1'b1; hv_a = '0; hv_b = 7'd120; msg = 3'd1; blink = 1'b0;
    #1;
    check("rst_hex_a", 64'(hex_a), 64'(56'hFF_FFFF_FFFF_FFFF >> 0) & 64'h00FF_FFFF_FFFF_FFFF);
    repeat (2) tick();
    check("rst_hex_b", 64'(hex_b), 64'h0000_03FF_FFFF_FFFF);
    check("rst_done_a", 64'(done_a), 64'd0);
    @(negedge clk) reset = 1'b0;

    // All-zero hands after the first refresh
    wait_done_a(cyc);
    tick();
    check("zero_hands", 64'(hex_a[55:28]), 64'({7'h7F, 7'h40, 7'h7F, 7'h40}));
    check("strt_msg", 64'(hex_a[27:0]), 64'(W_STRT));
    check("done_pulse", 64'(done_a), 64'd0);

    // Over-range on the 7-bit instance
    wait_done_b(cyc);
    wait_done_b(cyc);
    check("ovr_period", 64'(cyc), 64'd2);
    tick();
    check("ovr_dash", 64'(hex_b[41:28]), 64'({7'h3F, 7'h3F}));
    @(negedge clk) hv_b = 7'd99;
    wait_done_b(cyc);
    wait_done_b(cyc);
    check("b99_period", 64'(cyc), 64'd9);
    tick();
    check("b99_digits", 64'(hex_b[41:28]), 64'({7'h10, 7'h10}));

    // Hand0 = 21, hand1 = 9
    @(negedge clk) hv_a = {6'd9, 6'd21};
    wait_done_a(cyc);
    wait_done_a(cyc);
    check("refresh_period", 64'(cyc), 64'd16);
    tick();
    hands = {7'h7F, 7'h10, 7'h24, 7'h79};
    check("hands_21_9", 64'(hex_a[55:28]), 64'(hands));

    // Blink: WIN visible 8, blank 8, visible again
    @(negedge clk) begin blink = 1'b1; msg = 3'd3; end
    for (int i = 0; i < 17; i++) begin
      tick();
      check($sformatf("blink_win_%0d", i), 64'(hex_a),
            64'({hands, ((i % 16) < 8) ? W_WIN : W_BLANK}));
    end
    repeat (9) tick();
    check("blank_before_chg", 64'(hex_a), 64'({hands, W_BLANK}));
    @(negedge clk) msg = 3'd4;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("blink_lose_%0d", i), 64'(hex_a), 64'({hands, (i < 8) ? W_LOSE : W_BLANK}));
    end
    @(negedge clk) blink = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hex_a[27:0] !== W_LOSE) bad = 1'b1;
    end
    check("no_blink_when_off", 64'(bad), 64'd0);

    // Reset during hand1 SHIFT while hand1 changes 5 -> 30
    @(negedge clk) begin msg = 3'd1; hv_a = {6'd5, 6'd21}; end
    wait_done_a(cyc);
    wait_done_a(cyc);
    tick();
    check("hand1_5", 64'(hex_a[55:42]), 64'({7'h7F, 7'h12}));
    repeat (10) tick();
    hv_a = {6'd30, 6'd21};
    #2 reset = 1'b1;
    #1;
    check("midshift_rst_hex", 64'(hex_a), 64'h00FF_FFFF_FFFF_FFFF);
    check("midshift_rst_done", 64'(done_a), 64'd0);
    @(negedge clk) reset = 1'b0;
    bad = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (!(hex_a[55:49] inside {7'h7F, 7'h30}) || !(hex_a[48:42] inside {7'h7F, 7'h40})) bad = 1'b1;
    end while (!done_a && cyc < 100);
    check("post_rst_done", 64'(done_a), 64'd1);
    check("no_partial", 64'(bad), 64'd0);
    tick();
    check("hand1_30", 64'(hex_a), 64'({7'h30, 7'h40, 7'h24, 7'h79, W_STRT}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
